// File: rtl/shift_seq_counter_pkg.sv
// Shared encodings for the shift-sequence counter and its decoder.
package shift_seq_counter_pkg;

    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/shift_seq_counter_decode.sv
// Combinational pattern decoder: legality, sequence index and reset pattern
// for either Johnson or one-hot ring sequences.
module shift_seq_decode
    import shift_seq_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(2*WIDTH)
) (
    input  logic [WIDTH-1:0] pattern,
    input  logic             mode,
    output logic             legal,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] rp
);

    // One extra bit so 2*WIDTH and the popcount fit without wrapping.
    localparam int CW = IDX_W + 1;

    logic [CW-1:0]    ones;
    logic [CW-1:0]    trans;
    logic [IDX_W-1:0] hot;

    // Count set bits, adjacent-bit transitions, and locate the hot bit.
    always_comb begin
        ones  = '0;
        trans = '0;
        hot   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CW'(pattern[i]);
            if (pattern[i]) begin
                hot = IDX_W'(i);
            end
        end
        for (int i = 0; i < WIDTH-1; i++) begin
            if (pattern[i] != pattern[i+1]) begin
                trans = trans + CW'(1);
            end
        end
    end

    // Select legality, index and reset pattern for the requested mode.
    always_comb begin
        legal = 1'b0;
        idx   = '0;
        rp    = '0;
        if (mode == MODE_RING) begin
            legal = (ones == CW'(1));
            idx   = hot;
            rp    = WIDTH'(1);
        end else begin
            // Filling half counts ones; emptying half counts down from 2*WIDTH.
            legal = (trans <= CW'(1));
            idx   = IDX_W'(pattern[WIDTH-1] ? (CW'(2*WIDTH) - ones) : ones);
            rp    = '0;
        end
    end

endmodule

// File: rtl/shift_seq_counter.sv
// Johnson / one-hot ring shift-sequence counter with up/down, load,
// wrap pulse, decoded index and self-correction of illegal patterns.
module shift_seq_counter
    import shift_seq_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [IDX_W-1:0] idx,
    output logic             wrap,
    output logic             err
);

    logic             mode_q;
    logic             cur_legal;
    logic [IDX_W-1:0] cur_idx;
    logic [WIDTH-1:0] cur_rp;
    logic             ld_legal;
    logic [IDX_W-1:0] ld_idx;
    logic [WIDTH-1:0] new_rp;
    logic [IDX_W-1:0] last_idx;
    logic [WIDTH-1:0] step_pat;
    logic [IDX_W-1:0] step_idx;
    logic             step_wrap;
    logic             mode_d;
    logic [WIDTH-1:0] out_d;
    logic [IDX_W-1:0] idx_d;
    logic             wrap_d;
    logic             err_d;

    // Decode of the current pattern in the registered mode.
    shift_seq_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec_cur (
        .pattern (out),
        .mode    (mode_q),
        .legal   (cur_legal),
        .idx     (cur_idx),
        .rp      (cur_rp)
    );

    // Decode of load_val in the requested mode; its rp also serves reset and
    // mode change, and when a load is honoured the two modes are equal.
    shift_seq_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec_in (
        .pattern (load_val),
        .mode    (mode),
        .legal   (ld_legal),
        .idx     (ld_idx),
        .rp      (new_rp)
    );

    assign last_idx = (mode_q == MODE_RING) ? IDX_W'(WIDTH-1) : IDX_W'(2*WIDTH-1);

    // Next pattern, index and wrap for a single step in direction dir.
    always_comb begin
        step_pat  = out;
        step_idx  = cur_idx;
        step_wrap = 1'b0;
        if (mode_q == MODE_RING) begin
            step_pat = (dir == DIR_UP) ? {out[WIDTH-2:0], out[WIDTH-1]}
                                       : {out[0], out[WIDTH-1:1]};
        end else begin
            step_pat = (dir == DIR_UP) ? {out[WIDTH-2:0], ~out[WIDTH-1]}
                                       : {~out[0], out[WIDTH-1:1]};
        end
        if (dir == DIR_UP) begin
            step_wrap = (cur_idx == last_idx);
            step_idx  = step_wrap ? '0 : cur_idx + IDX_W'(1);
        end else begin
            step_wrap = (cur_idx == '0);
            step_idx  = step_wrap ? last_idx : cur_idx - IDX_W'(1);
        end
    end

    // Priority mux: mode change, load, correction, step, hold.
    always_comb begin
        mode_d = mode_q;
        out_d  = out;
        idx_d  = idx;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (mode != mode_q) begin
            mode_d = mode;
            out_d  = new_rp;
            idx_d  = '0;
        end else if (load) begin
            if (ld_legal) begin
                out_d = load_val;
                idx_d = ld_idx;
            end else begin
                out_d = new_rp;
                idx_d = '0;
                err_d = 1'b1;
            end
        end else if (en) begin
            if (!cur_legal) begin
                out_d = cur_rp;
                idx_d = '0;
                err_d = 1'b1;
            end else begin
                out_d  = step_pat;
                idx_d  = step_idx;
                wrap_d = step_wrap;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= mode;
            out    <= new_rp;
            idx    <= '0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            mode_q <= mode_d;
            out    <= out_d;
            idx    <= idx_d;
            wrap   <= wrap_d;
            err    <= err_d;
        end
    end

endmodule

// File: doc/shift_seq_counter.md
Name: shift_seq_counter

Overview:
Parametrised synchronous shift-sequence counter that generates either a Johnson (twisted-ring) or a one-hot ring sequence of configurable width. It supports up/down, enable, parallel load, a terminal wrap pulse, a decoded sequence index, and self-correction of illegal patterns. Used as a drop-in multi-phase sequencer and timing generator in lab designs, replacing fixed 4-bit Johnson counters.

Parameters:
WIDTH, 4, number of flip-flops in the shift register (>=2).
IDX_W, $clog2(2*WIDTH), width of the index output.

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  synchronous, active-low reset.
en  in  1  count enable; advance one step per cycle while high.
dir  in  1  0 = up, 1 = down.
mode  in  1  0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states).
load  in  1  parallel load strobe.
load_val  in  WIDTH  value to load.
out  out  WIDTH  current pattern (registered).
idx  out  IDX_W  position of out in the sequence, 0..LEN-1 (registered).
wrap  out  1  one-cycle pulse on sequence wrap (registered).
err  out  1  one-cycle pulse when an illegal pattern was corrected (registered).

Behaviour:
- Reset (rst=0 at posedge): Johnson mode: out=0, idx=0. Ring mode: out=1 (bit0 hot), idx=0. wrap=0, err=0. The registered mode is also loaded from the mode input.
- Reset pattern per mode is called RP below. LEN = 2*WIDTH for Johnson, WIDTH for ring.
- Johnson up: shift left, bit0 <= ~out[WIDTH-1]. W=4: 0000,0001,0011,0111,1111,1110,1100,1000,0000.
- Johnson down: shift right, msb <= ~out[0]. This is the exact reverse of the up sequence.
- Ring up: rotate left (0001,0010,0100,1000,0001). Ring down: rotate right.
- idx: Johnson: if msb=0, idx=popcount(out); otherwise idx = 2*WIDTH - popcount(out). Ring: idx = index of the hot bit. idx is always consistent with out in the same cycle.
- Legal patterns: Johnson = at most one transition between adjacent bits b[i], b[i+1] for i=0..WIDTH-2. Ring = exactly one bit set.
- Priority per posedge, highest first:
  1. Reset.
  2. Mode change: mode differs from the registered mode. out=RP of the new mode, idx=0, no wrap, no err.
  3. Load: if load_val is legal, out=load_val. If illegal, out=RP and err=1.
  4. Illegal out while en=1: out=RP, err=1, no count.
  5. en=1: one step in direction dir.
  6. Otherwise hold.
- Load takes priority over en when both are asserted in the same cycle; no count occurs that cycle.
- err also fires when out is illegal with en=0? No: with en=0 the counter holds. Correction happens on the next enabled step or on a load.
- wrap=1 for exactly the one cycle in which out has just reached idx 0 via an up step from idx LEN-1, or has just reached idx LEN-1 via a down step from idx 0. wrap=0 after load, mode change, correction, or reset.
- Direction reversal mid-sequence takes effect on the next step with no glitch or skip.
- Latency: 1 cycle from input to out, idx, wrap and err.

Decomposition:
- Shared package: mode encodings MODE_JOHNSON=0 and MODE_RING=1, and DIR_UP=0 / DIR_DOWN=1.
- One sub-module, shift_seq_decode (purely combinational, parametrised by WIDTH). Inputs: pattern and mode. Outputs: legal flag, idx, and RP. It is reused for both the out path and the load_val check.
- The top level holds the registers, the priority mux and the next-pattern shift logic.

Test Plan:
- W=4, Johnson, reset then en=1, dir=0 for 9 cycles -> out 0000,0001,0011,0111,1111,1110,1100,1000,0000 with idx 0..7,0; wrap=1 only on the final 0000.
- Johnson, dir=1 from reset for 2 cycles -> out 1000 (idx 7, wrap=1), then 1100 (idx 6, wrap=0).
- Ring mode: switch mode to 1 -> out=0001, idx=0 next cycle. en=1, dir=0 for 4 cycles -> 0010,0100,1000,0001; wrap on 0001.
- Johnson, load with load_val=0101 (illegal) -> out=0000, err=1 for one cycle. Load 0111 with en=1 in the same cycle -> out=0111, idx=3, no count.
- Force rst=0 mid-count at out=1110 -> out=0000, idx=0, wrap=0, err=0 on that edge. Also dir toggled at 0011 -> next out 0001.
- WIDTH=5 instance, Johnson, 10 up steps -> returns to 00000 with wrap=1, and idx spans 0..9.
